reg_file_mp: RTL and testbench

//  Parametrised multi-port integer register file with per-register pending-write scoreboard.

---
 rtl/reg_file_mp_pkg.sv | 12 +
 rtl/reg_file_mp_scoreboard.sv | 57 +++++
 rtl/reg_file_mp.sv | 114 +++++++++++
 tb/tb_reg_file_mp.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults for the multi-port register file and its scoreboard.
//   XLEN_DEF / NREG_DEF / NUM_RD_DEF / NUM_WR_DEF : default geometry
//   ZERO_REG                                      : hardwired-zero entry index
package reg_file_mp_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned NREG_DEF   = 32;
    localparam int unsigned NUM_RD_DEF = 4;
    localparam int unsigned NUM_WR_DEF = 2;
    localparam int unsigned ZERO_REG   = 0;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// reg_scoreboard: per-register pending-write bits.
// Ports:
//   clk_i, rst_i     clock (rising edge), asynchronous active-high reset
//   wen_i, waddr_i   writeback ports; a write clears the target's busy bit
//   alloc_en_i/addr  issue-stage destination allocation; sets busy
//   flush_i          clears every busy bit, overriding a same-cycle alloc
//   busy_vec_o       registered busy vector, bit 0 always 0
module reg_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned AW     = $clog2(NREG),
    parameter int unsigned NUM_WR = NUM_WR_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_WR-1:0]    wen_i,
    input  logic [NUM_WR*AW-1:0] waddr_i,
    input  logic                 alloc_en_i,
    input  logic [AW-1:0]        alloc_addr_i,
    input  logic                 flush_i,
    output logic [NREG-1:0]      busy_vec_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear by writes first, then alloc on top so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NREG; r++) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wen_i[j] && (waddr_i[j*AW +: AW] == AW'(r))) begin
                    busy_d[r] = 1'b0;
                end
            end
            if (alloc_en_i && (alloc_addr_i == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with pending-write scoreboard.
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   raddr_i / rdata_o     NUM_RD combinational read ports (port k at [k*AW +: AW])
//   rbusy_o               addressed register has a pending write
//   wen_i/waddr_i/wdata_i NUM_WR write ports; highest port index wins on collision
//   alloc_en_i/addr_i     mark a destination pending at the next edge
//   flush_i               clear all busy bits
//   busy_vec_o            registered scoreboard, bit 0 always 0
// Configuration macro: REG_FILE_BYPASS_EN enables same-cycle write-to-read
// forwarding of data and busy state.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned AW     = $clog2(NREG),
    parameter int unsigned NUM_RD = NUM_RD_DEF,
    parameter int unsigned NUM_WR = NUM_WR_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_RD*AW-1:0]   raddr_i,
    output logic [NUM_RD*XLEN-1:0] rdata_o,
    output logic [NUM_RD-1:0]      rbusy_o,
    input  logic [NUM_WR-1:0]      wen_i,
    input  logic [NUM_WR*AW-1:0]   waddr_i,
    input  logic [NUM_WR*XLEN-1:0] wdata_i,
    input  logic                   alloc_en_i,
    input  logic [AW-1:0]          alloc_addr_i,
    input  logic                   flush_i,
    output logic [NREG-1:0]        busy_vec_o
);

    logic [XLEN-1:0] data_q [NREG];
    logic [XLEN-1:0] data_d [NREG];
    logic [NREG-1:0] busy_vec;

    reg_scoreboard #(
        .NREG   (NREG),
        .AW     (AW),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wen_i        (wen_i),
        .waddr_i      (waddr_i),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .flush_i      (flush_i),
        .busy_vec_o   (busy_vec)
    );

    assign busy_vec_o = busy_vec;

    // Ascending port loop: the last (highest) matching port wins.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            data_d[r] = data_q[r];
        end
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wen_i[j]) begin
                data_d[waddr_i[j*AW +: AW]] = wdata_i[j*XLEN +: XLEN];
            end
        end
        data_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                data_q[r] <= data_d[r];
            end
        end
    end

    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_val;
    logic            rd_busy;

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        rd_addr = '0;
        rd_val  = '0;
        rd_busy = 1'b0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_addr = raddr_i[k*AW +: AW];
            rd_val  = data_q[rd_addr];
            rd_busy = busy_vec[rd_addr];
`ifdef REG_FILE_BYPASS_EN
            // A forwarded write resolves the hazard unless the same cycle
            // re-allocates the register to a new producer.
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wen_i[j] && (waddr_i[j*AW +: AW] == rd_addr)) begin
                    rd_val  = wdata_i[j*XLEN +: XLEN];
                    rd_busy = alloc_en_i && (alloc_addr_i == rd_addr) && !flush_i;
                end
            end
`endif
            if (rst_i || (rd_addr == AW'(ZERO_REG))) begin
                rd_val  = '0;
                rd_busy = 1'b0;
            end
            rdata_o[k*XLEN +: XLEN] = rd_val;
            rbusy_o[k]              = rd_busy;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_RD*AW-1:0]   raddr_i;
    logic [NUM_RD*XLEN-1:0] rdata_o;
    logic [NUM_RD-1:0]      rbusy_o;
    logic [NUM_WR-1:0]      wen_i;
    logic [NUM_WR*AW-1:0]   waddr_i;
    logic [NUM_WR*XLEN-1:0] wdata_i;
    logic                   alloc_en_i;
    logic [AW-1:0]          alloc_addr_i;
    logic                   flush_i;
    logic [NREG-1:0]        busy_vec_o;

    int tests = 0;
    int fails = 0;

    reg_file_mp #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .AW     (AW),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .raddr_i      (raddr_i),
        .rdata_o      (rdata_o),
        .rbusy_o      (rbusy_o),
        .wen_i        (wen_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .flush_i      (flush_i),
        .busy_vec_o   (busy_vec_o)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register values and pending flags.
    logic [XLEN-1:0] m_data [NREG];
    bit              m_busy [NREG];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_data[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            bit written [NREG];
            for (int r = 0; r < NREG; r++) written[r] = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wen_i[j]) begin
                    int a;
                    a = int'(waddr_i[j*AW +: AW]);
                    written[a] = 1'b1;
                    if (a != 0) m_data[a] = wdata_i[j*XLEN +: XLEN];
                end
            end
            for (int r = 1; r < NREG; r++) begin
                if (flush_i) m_busy[r] = 1'b0;
                else if (alloc_en_i && int'(alloc_addr_i) == r) m_busy[r] = 1'b1;
                else if (written[r]) m_busy[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [NREG-1:0] exp_vec;
        for (int r = 0; r < NREG; r++) exp_vec[r] = m_busy[r];
        chk("busy_vec", 64'(busy_vec_o), 64'(exp_vec));
        for (int k = 0; k < NUM_RD; k++) begin
            int a;
            logic [XLEN-1:0] ed;
            logic eb;
            a  = int'(raddr_i[k*AW +: AW]);
            ed = m_data[a];
            eb = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wen_i[j] && int'(waddr_i[j*AW +: AW]) == a) begin
                    ed = wdata_i[j*XLEN +: XLEN];
                    eb = alloc_en_i && int'(alloc_addr_i) == a && !flush_i;
                end
            end
`endif
            if (rst || a == 0) begin
                ed = '0;
                eb = 1'b0;
            end
            chk($sformatf("rdata%0d", k), 64'(rdata_o[k*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("rbusy%0d", k), 64'(rbusy_o[k]), 64'(eb));
        end
    end

    task automatic idle();
        wen_i = '0; waddr_i = '0; wdata_i = '0;
        alloc_en_i = 1'b0; alloc_addr_i = '0; flush_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int j, input int a, input logic [XLEN-1:0] d);
        wen_i[j] = 1'b1;
        waddr_i[j*AW +: AW] = AW'(a);
        wdata_i[j*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int k, input int a);
        raddr_i[k*AW +: AW] = AW'(a);
    endtask

    function automatic logic [XLEN-1:0] port_data(input int k);
        return rdata_o[k*XLEN +: XLEN];
    endfunction

    initial begin
        rst = 1'b1;
        raddr_i = '0;
        idle();
        #1;
        chk("reset_busy_vec", 64'(busy_vec_o), 64'h0);
        chk("reset_rdata0", 64'(port_data(0)), 64'h0);
        step();
        step();
        rst = 1'b0;

        // Colliding writes to x7, port 1 wins; write to x0 is dropped.
        wr(0, 7, 32'h11); wr(1, 7, 32'h22);
        step();
        idle();
        wr(0, 0, 32'hFF);
        rd(0, 7); rd(1, 0);
        #2;
        chk("x7_port_priority", 64'(port_data(0)), 64'h22);
        step();
        idle();
        #2;
        chk("x0_reads_zero", 64'(port_data(1)), 64'h0);

        // Alloc x3, then write+alloc x3 keeps busy, then plain write clears it.
        step();
        alloc_en_i = 1'b1; alloc_addr_i = 5'd3;
        step();
        idle();
        #2;
        chk("x3_alloc_busy", 64'(busy_vec_o[3]), 64'h1);
        wr(0, 3, 32'h55); alloc_en_i = 1'b1; alloc_addr_i = 5'd3;
        step();
        idle();
        rd(0, 3);
        #2;
        chk("x3_realloc_busy", 64'(busy_vec_o[3]), 64'h1);
        chk("x3_data_55", 64'(port_data(0)), 64'h55);
        wr(1, 3, 32'h66);
        step();
        idle();
        #2;
        chk("x3_write_clears", 64'(busy_vec_o[3]), 64'h0);
        chk("x3_data_66", 64'(port_data(0)), 64'h66);

        // Flush drops a same-cycle alloc and clears all pending bits.
        alloc_en_i = 1'b1; alloc_addr_i = 5'd9; flush_i = 1'b1;
        step();
        idle();
        #2;
        chk("x9_alloc_flushed", 64'(busy_vec_o[9]), 64'h0);
        alloc_en_i = 1'b1; alloc_addr_i = 5'd4;
        step();
        alloc_addr_i = 5'd9;
        step();
        idle();
        #2;
        chk("busy_x4_x9", 64'(busy_vec_o), 64'h0000_0210);
        flush_i = 1'b1;
        step();
        idle();
        rd(0, 7); rd(1, 3);
        #2;
        chk("flush_clears_all", 64'(busy_vec_o), 64'h0);
        chk("flush_keeps_x7", 64'(port_data(0)), 64'h22);
        chk("flush_keeps_x3", 64'(port_data(1)), 64'h66);

        // x6=1 busy, then read while writing 0x77.
        wr(0, 6, 32'h1); alloc_en_i = 1'b1; alloc_addr_i = 5'd6;
        step();
        idle();
        rd(0, 6);
        wr(1, 6, 32'h77);
        #2;
`ifdef REG_FILE_BYPASS_EN
        chk("bypass_rdata", 64'(port_data(0)), 64'h77);
        chk("bypass_rbusy", 64'(rbusy_o[0]), 64'h0);
`else
        chk("nobypass_rdata", 64'(port_data(0)), 64'h1);
        chk("nobypass_rbusy", 64'(rbusy_o[0]), 64'h1);
`endif
        step();
        idle();
        #2;
        chk("x6_after_rdata", 64'(port_data(0)), 64'h77);
        chk("x6_after_rbusy", 64'(rbusy_o[0]), 64'h0);

        // Reset asserted between edges with x5 busy.
        wr(0, 5, 32'hDEADBEEF); alloc_en_i = 1'b1; alloc_addr_i = 5'd5;
        step();
        idle();
        rd(0, 5);
        #1;
        chk("x5_before_reset", 64'(port_data(0)), 64'hDEADBEEF);
        chk("x5_busy_before_reset", 64'(busy_vec_o[5]), 64'h1);
        rst = 1'b1;
        #1;
        chk("midreset_rdata", 64'(port_data(0)), 64'h0);
        chk("midreset_busy_vec", 64'(busy_vec_o), 64'h0);
        step();
        rst = 1'b0;

        // All read ports: distinct then identical addresses.
        wr(0, 1, 32'hA1); wr(1, 2, 32'hB2);
        step();
        idle();
        wr(0, 3, 32'hC3); wr(1, 4, 32'hD4);
        step();
        idle();
        for (int k = 0; k < NUM_RD; k++) rd(k, k + 1);
        #2;
        chk("distinct_p3", 64'(port_data(3)), 64'hD4);
        step();
        for (int k = 0; k < NUM_RD; k++) rd(k, 2);
        #2;
        for (int k = 0; k < NUM_RD; k++) chk($sformatf("same_p%0d", k), 64'(port_data(k)), 64'hB2);
        step();

        // Random traffic, checked every cycle by the compare process.
        for (int c = 0; c < 1000; c++) begin
            wen_i        = NUM_WR'($urandom_range(0, 3));
            waddr_i      = (NUM_WR*AW)'($urandom);
            wdata_i      = {$urandom, $urandom};
            alloc_en_i   = 1'($urandom_range(0, 1));
            alloc_addr_i = AW'($urandom);
            flush_i      = ($urandom_range(0, 15) == 0);
            if (c % 8 == 0) begin
                int a;
                a = int'($urandom_range(0, NREG - 1));
                for (int k = 0; k < NUM_RD; k++) rd(k, a);
            end else begin
                raddr_i = (NUM_RD*AW)'({$urandom, $urandom});
            end
            if (c % 5 == 0) begin
                waddr_i[AW +: AW] = raddr_i[0 +: AW];
                alloc_addr_i      = raddr_i[0 +: AW];
            end
            step();
        end
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
